// File: rtl/coax_pkg.sv
// coax_pkg: shared word width and transmit-feeder FSM encoding.
package coax_pkg;
    localparam int COAX_WORD_WIDTH = 10;
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} tx_state_e;
endpackage

// File: rtl/coax_fifo.sv
// coax_fifo: synchronous FIFO; head is valid whenever empty is low.
module coax_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign head  = mem_q[rd_ptr_q];
    // a push while full is refused even if a pop frees a slot this same cycle
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/coax_buffered_tx.sv
// coax_buffered_tx: buffers coax words and feeds them to coax_tx over strobe/ready.
module coax_buffered_tx
    import coax_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [COAX_WORD_WIDTH-1:0] data,
    input  logic                       strobe,
    output logic                       full,
    output logic                       empty,
    output logic                       active,
    output logic                       error,
    output logic [COAX_WORD_WIDTH-1:0] tx_data,
    output logic                       tx_strobe,
    input  logic                       tx_ready,
    input  logic                       tx_active
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    tx_state_e                  state_q, state_d;
    logic [TW-1:0]              timer_q, timer_d;
    logic [COAX_WORD_WIDTH-1:0] tx_data_q, tx_data_d, head;
    logic                       tx_strobe_q, tx_strobe_d, error_q, error_d, pop;
    coax_fifo #(.WIDTH(COAX_WORD_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (strobe),
        .pop   (pop),
        .wdata (data),
        .head  (head),
        .full  (full),
        .empty (empty)
    );
    assign pop       = state_q == IDLE && !empty && tx_ready;
    assign active    = !empty || tx_active || state_q != IDLE;
    assign error     = error_q;
    assign tx_data   = tx_data_q;
    assign tx_strobe = tx_strobe_q;
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        tx_data_d   = tx_data_q;
        tx_strobe_d = 1'b0;
        error_d     = error_q || (strobe && full);
        if (state_q == IDLE) begin
            if (pop) begin
                tx_data_d   = head;
                tx_strobe_d = 1'b1;
                timer_d     = '0;
                state_d     = HOLD;
            end
        end else begin
            timer_d = timer_q + 1'b1;
            // a fall of tx_ready means the word was taken; otherwise give up after the timeout
            if (!tx_ready) begin
                state_d = IDLE;
            end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
                error_d = 1'b1;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            tx_data_q   <= '0;
            tx_strobe_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            tx_data_q   <= tx_data_d;
            tx_strobe_q <= tx_strobe_d;
            error_q     <= error_d;
        end
    end
endmodule

// File: tb/tb_coax_buffered_tx.sv
// tb_coax_buffered_tx: directed checks of buffering, ordering, overflow, timeout and reset.
module tb_coax_buffered_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] data = '0;
    logic       strobe = 1'b0;
    logic       tx_ready = 1'b0;
    logic       tx_active = 1'b0;
    logic       full, empty, active, error, tx_strobe;
    logic [9:0] tx_data;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_strobe = 0;
    int         snap;

    coax_buffered_tx #(.DEPTH(4), .ACK_TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .strobe    (strobe),
        .full      (full),
        .empty     (empty),
        .active    (active),
        .error     (error),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .tx_ready  (tx_ready),
        .tx_active (tx_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (tx_strobe) n_strobe++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_word(input logic [9:0] d);
        data   = d;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
    endtask

    task automatic deliver(input logic [9:0] exp, input string tag);
        int k = 0;
        tx_ready = 1'b1;
        do begin
            tick();
            k++;
        end while (!tx_strobe && k < 10);
        check({tag, "_strobe"}, 32'(tx_strobe), 1);
        check({tag, "_data"}, 32'(tx_data), 32'(exp));
        tx_ready = 1'b0;
        tick();
    endtask

    initial begin
        // T1 reset
        tick();
        do_reset();
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_error", 32'(error), 0);
        check("rst_strobe", 32'(tx_strobe), 0);
        check("rst_data", 32'(tx_data), 0);
        check("rst_active", 32'(active), 0);

        // T2 single word: strobe appears the cycle after the following edge
        tx_ready = 1'b1;
        push_word(10'h175);
        check("t2_empty_after_push", 32'(empty), 0);
        check("t2_no_early_strobe", 32'(tx_strobe), 0);
        tick();
        check("t2_strobe", 32'(tx_strobe), 1);
        check("t2_data", 32'(tx_data), 32'h175);
        check("t2_empty", 32'(empty), 1);
        check("t2_active_hold", 32'(active), 1);
        tx_ready = 1'b0;
        tick();
        check("t2_strobe_pulse", 32'(tx_strobe), 0);
        check("t2_idle", 32'(active), 0);
        check("t2_data_stable", 32'(tx_data), 32'h175);

        // T3 ordering with tx_ready held low
        snap = n_strobe;
        push_word(10'h175);
        push_word(10'h28E);
        push_word(10'h3FF);
        repeat (5) tick();
        check("t3_no_strobe", 32'(n_strobe - snap), 0);
        check("t3_active_queued", 32'(active), 1);
        deliver(10'h175, "t3_w0");
        deliver(10'h28E, "t3_w1");
        deliver(10'h3FF, "t3_w2");
        check("t3_empty", 32'(empty), 1);

        // T4 overflow with DEPTH=4
        do_reset();
        push_word(10'h001);
        push_word(10'h102);
        push_word(10'h203);
        check("t4_not_full_3", 32'(full), 0);
        push_word(10'h3F4);
        check("t4_full_4", 32'(full), 1);
        check("t4_no_error_yet", 32'(error), 0);
        push_word(10'h155);
        check("t4_error", 32'(error), 1);
        check("t4_still_full", 32'(full), 1);
        deliver(10'h001, "t4_w0");
        deliver(10'h102, "t4_w1");
        deliver(10'h203, "t4_w2");
        deliver(10'h3F4, "t4_w3");
        snap = n_strobe;
        tx_ready = 1'b1;
        repeat (6) tick();
        check("t4_no_extra", 32'(n_strobe - snap), 0);
        check("t4_empty", 32'(empty), 1);
        check("t4_error_sticky", 32'(error), 1);
        tx_ready = 1'b0;

        // T5 ack timeout with ACK_TIMEOUT=16
        do_reset();
        check("t5_error_cleared", 32'(error), 0);
        push_word(10'h0AA);
        push_word(10'h255);
        tx_ready = 1'b1;
        tick();
        check("t5_strobe_a", 32'(tx_strobe), 1);
        check("t5_data_a", 32'(tx_data), 32'h0AA);
        repeat (15) tick();
        check("t5_no_error_15", 32'(error), 0);
        tick();
        check("t5_error_16", 32'(error), 1);
        tick();
        check("t5_strobe_b", 32'(tx_strobe), 1);
        check("t5_data_b", 32'(tx_data), 32'h255);
        tx_ready = 1'b0;
        tick();
        check("t5_empty", 32'(empty), 1);

        // T6 reset while in HOLD discards the rest
        do_reset();
        push_word(10'h111);
        push_word(10'h222);
        tx_ready = 1'b1;
        tick();
        check("t6_strobe", 32'(tx_strobe), 1);
        check("t6_data", 32'(tx_data), 32'h111);
        do_reset();
        check("t6_empty", 32'(empty), 1);
        check("t6_strobe_clr", 32'(tx_strobe), 0);
        check("t6_data_clr", 32'(tx_data), 0);
        snap = n_strobe;
        repeat (100) tick();
        check("t6_no_strobe", 32'(n_strobe - snap), 0);
        check("t6_idle", 32'(active), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
